// File: rtl/vram_arbiter_if.sv
// Bundle of requester, arbiter and RAM-port signals for vram_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface vram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NREQ requesters,
// granting bursts of up to MAX_BURST beats with one IDLE cycle between grants.
module vram_arbiter #(
    parameter int NREQ      = 4,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    vram_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NREQ);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   next_ptr;
    logic            owner_req;
    logic            owner_we;
    logic [AW-1:0]   owner_addr;
    logic [DW-1:0]   owner_wdata;

    // Grants and read-valids are masked during reset so no beat or stale
    // read completion is visible while rst is high.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign gnt[gi]        = !rst && (state_q == ST_OWN) && (owner_q == OW'(gi)) && bus.req[gi];
            assign rvalid_d[gi]   = gnt[gi] & ~bus.req_we[gi];
            assign bus.gnt[gi]    = gnt[gi];
            assign bus.rvalid[gi] = rvalid_q[gi] & ~rst;
        end
    endgenerate

    // Rotating priority search: first request at or above ptr, wrapping.
    always_comb begin
        logic [OW:0]   sum;
        logic [OW-1:0] cand;
        logic          found;
        pick  = ptr_q;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (OW+1)'(k);
            if (sum >= (OW+1)'(NREQ)) begin
                sum = sum - (OW+1)'(NREQ);
            end
            cand = sum[OW-1:0];
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req   = 1'b0;
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_req   = bus.req[i];
                owner_we    = bus.req_we[i];
                owner_addr  = bus.req_addr[i*AW +: AW];
                owner_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    assign next_ptr = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_OWN;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(MAX_BURST - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_ptr;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = bus.mem_en & owner_we;
    assign bus.mem_addr  = owner_addr;
    assign bus.mem_wdata = owner_wdata;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.busy      = (state_q == ST_OWN);
endmodule

// File: tb/tb_vram_arbiter.sv
// Scenario bench for vram_arbiter: per-cycle grant expectations and a
// one-cycle-delayed read-valid scoreboard, with a behavioural RAM per DUT.
module tb_vram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    vram_arbiter_if #(.NREQ(4), .AW(16), .DW(8)) bus0();
    vram_arbiter_if #(.NREQ(4), .AW(16), .DW(8)) bus1();

    vram_arbiter #(.NREQ(4), .AW(16), .DW(8), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(bus0)
    );
    vram_arbiter #(.NREQ(4), .AW(16), .DW(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );

    // RAM contents: unwritten locations return a fixed pattern.
    function automatic logic [7:0] rom_val(logic [15:0] a);
        if (a == 16'h0010) return 8'hA5;
        if (a[15:4] == 12'h002) return {4'h5, a[3:0]};
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_data(int o);
        return (o == 0) ? 8'hA5 : 8'(8'h50 + o);
    endfunction

    logic [7:0]   ram0 [0:255];
    logic [255:0] wr0;
    logic [7:0]   rd0_q;
    logic [7:0]   rd1_q;

    always @(posedge clk) begin
        if (rst0) begin
            wr0 <= '0;
        end else if (bus0.mem_en) begin
            if (bus0.mem_we) begin
                ram0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
                wr0[bus0.mem_addr[7:0]]  <= 1'b1;
            end else begin
                rd0_q <= wr0[bus0.mem_addr[7:0]] ? ram0[bus0.mem_addr[7:0]] : rom_val(bus0.mem_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (bus1.mem_en && !bus1.mem_we) rd1_q <= rom_val(bus1.mem_addr);
    end

    assign bus0.mem_rdata = rd0_q;
    assign bus1.mem_rdata = rd1_q;

    typedef struct packed { logic [3:0] gnt; logic busy; } cyc_t;
    typedef struct packed { logic [3:0] rv; logic [7:0] data; } rv_t;
    cyc_t exp_q[$];
    rv_t  rv_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.req = '0; bus1.req = '0;
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        exp_q.delete();
        rv_q.delete();
        rv_q.push_back('{rv: 4'b0000, data: 8'h00});
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst0 = 1'b1;
        bus0.req = 4'b1111; bus0.req_we = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (bus0.gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", bus0.gnt); else n_pass++;
        if (bus0.mem_en !== 1'b0) $display("FAIL reset_mem_en got %b exp 0", bus0.mem_en); else n_pass++;
        if (bus0.rvalid !== 4'b0000) $display("FAIL reset_rvalid got %b exp 0000", bus0.rvalid); else n_pass++;
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus0.gnt !== 4'b0000) $display("FAIL post_reset_gnt got %b exp 0000", bus0.gnt); else n_pass++;
        if (bus0.busy !== 1'b0) $display("FAIL post_reset_busy got %b exp 0", bus0.busy); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus0.gnt !== 4'b0001) $display("FAIL first_grant got %b exp 0001", bus0.gnt); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_single_burst();
        cyc_t e;
        rv_t  r;
        logic [3:0] g;
        apply_reset();
        bus0.req_we = 4'b0000;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            bus0.req = (c <= 7) ? 4'b0001 : 4'b0000;
            g = ((c >= 1 && c <= 4) || c == 6 || c == 7) ? 4'b0001 : 4'b0000;
            exp_q.push_back('{gnt: g, busy: ((c >= 1 && c <= 4) || (c >= 6 && c <= 8))});
            rv_q.push_back('{rv: g, data: 8'hA5});
            @(negedge clk);
            e = exp_q.pop_front();
            r = rv_q.pop_front();
            n_checks += 3;
            if (bus0.gnt !== e.gnt) $display("FAIL burst c%0d gnt got %b exp %b", c, bus0.gnt, e.gnt); else n_pass++;
            if (bus0.busy !== e.busy) $display("FAIL burst c%0d busy got %b exp %b", c, bus0.busy, e.busy); else n_pass++;
            if (bus0.rvalid !== r.rv) $display("FAIL burst c%0d rvalid got %b exp %b", c, bus0.rvalid, r.rv); else n_pass++;
            if (r.rv != 4'b0000) begin
                n_checks++;
                if (bus0.rdata !== r.data) $display("FAIL burst c%0d rdata got %h exp %h", c, bus0.rdata, r.data); else n_pass++;
            end
            $display("burst c%0d gnt=%b rvalid=%b busy=%b", c, bus0.gnt, bus0.rvalid, bus0.busy);
        end
    endtask

    task automatic test_rotation();
        cyc_t e;
        rv_t  r;
        logic [3:0] g;
        int o;
        apply_reset();
        bus0.req_we = 4'b0000;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            bus0.req = 4'b1111;
            o = (c / 5) % 4;
            g = (c % 5 == 0) ? 4'b0000 : 4'(1 << o);
            exp_q.push_back('{gnt: g, busy: (c % 5 != 0)});
            rv_q.push_back('{rv: g, data: exp_data(o)});
            @(negedge clk);
            e = exp_q.pop_front();
            r = rv_q.pop_front();
            n_checks += 4;
            if (bus0.gnt !== e.gnt) $display("FAIL rotate c%0d gnt got %b exp %b", c, bus0.gnt, e.gnt); else n_pass++;
            if ($countones(bus0.gnt) > 1) $display("FAIL rotate c%0d onehot got %b exp at most one bit", c, bus0.gnt); else n_pass++;
            if (bus0.busy !== e.busy) $display("FAIL rotate c%0d busy got %b exp %b", c, bus0.busy, e.busy); else n_pass++;
            if (bus0.rvalid !== r.rv) $display("FAIL rotate c%0d rvalid got %b exp %b", c, bus0.rvalid, r.rv); else n_pass++;
            if (r.rv != 4'b0000) begin
                n_checks++;
                if (bus0.rdata !== r.data) $display("FAIL rotate c%0d rdata got %h exp %h", c, bus0.rdata, r.data); else n_pass++;
            end
            $display("rotate c%0d gnt=%b rvalid=%b", c, bus0.gnt, bus0.rvalid);
        end
    endtask

    task automatic test_wrap();
        cyc_t e;
        logic [3:0] g;
        apply_reset();
        bus0.req_we = 4'b0000;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            bus0.req = (c <= 4) ? 4'b1000 : 4'b1001;
            if (c >= 1 && c <= 4)       g = 4'b1000;
            else if (c >= 6 && c <= 9)  g = 4'b0001;
            else if (c >= 11)           g = 4'b1000;
            else                        g = 4'b0000;
            exp_q.push_back('{gnt: g, busy: (g != 4'b0000)});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 2;
            if (bus0.gnt !== e.gnt) $display("FAIL wrap c%0d gnt got %b exp %b", c, bus0.gnt, e.gnt); else n_pass++;
            if (bus0.busy !== e.busy) $display("FAIL wrap c%0d busy got %b exp %b", c, bus0.busy, e.busy); else n_pass++;
            $display("wrap c%0d req=%b gnt=%b", c, bus0.req, bus0.gnt);
        end
    endtask

    task automatic test_write();
        cyc_t e;
        rv_t  r;
        logic [3:0] g;
        apply_reset();
        bus0.req_we = 4'b0100;
        bus0.req_addr[2*16 +: 16] = 16'h00FF;
        bus0.req_wdata[2*8 +: 8]  = 8'h3C;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c <= 2)                 bus0.req = 4'b0100;
            else if (c == 4 || c == 5)  bus0.req = 4'b1100;
            else                        bus0.req = 4'b0000;
            if (c == 1 || c == 2) g = 4'b0100;
            else if (c == 5)      g = 4'b1000;
            else                  g = 4'b0000;
            exp_q.push_back('{gnt: g, busy: (c != 0 && c != 4)});
            rv_q.push_back('{rv: (c == 5) ? 4'b1000 : 4'b0000, data: 8'h53});
            @(negedge clk);
            e = exp_q.pop_front();
            r = rv_q.pop_front();
            n_checks += 3;
            if (bus0.gnt !== e.gnt) $display("FAIL write c%0d gnt got %b exp %b", c, bus0.gnt, e.gnt); else n_pass++;
            if (bus0.busy !== e.busy) $display("FAIL write c%0d busy got %b exp %b", c, bus0.busy, e.busy); else n_pass++;
            if (bus0.rvalid !== r.rv) $display("FAIL write c%0d rvalid got %b exp %b", c, bus0.rvalid, r.rv); else n_pass++;
            if (e.gnt == 4'b0100) begin
                n_checks += 3;
                if (bus0.mem_we !== 1'b1) $display("FAIL write c%0d mem_we got %b exp 1", c, bus0.mem_we); else n_pass++;
                if (bus0.mem_addr !== 16'h00FF) $display("FAIL write c%0d mem_addr got %h exp 00ff", c, bus0.mem_addr); else n_pass++;
                if (bus0.mem_wdata !== 8'h3C) $display("FAIL write c%0d mem_wdata got %h exp 3c", c, bus0.mem_wdata); else n_pass++;
            end
            if (r.rv != 4'b0000) begin
                n_checks++;
                if (bus0.rdata !== r.data) $display("FAIL write c%0d rdata got %h exp %h", c, bus0.rdata, r.data); else n_pass++;
            end
            $display("write c%0d gnt=%b mem_we=%b mem_addr=%h", c, bus0.gnt, bus0.mem_we, bus0.mem_addr);
        end
        n_checks++;
        if (!(wr0[8'hFF] === 1'b1 && ram0[8'hFF] === 8'h3C))
            $display("FAIL write ram_ff got %h exp 3c", ram0[8'hFF]);
        else
            n_pass++;
        bus0.req_we = 4'b0000;
        bus0.req_addr[2*16 +: 16] = 16'h0022;
    endtask

    task automatic test_reset_mid_read();
        cyc_t e;
        rv_t  r;
        logic [3:0] g;
        apply_reset();
        bus0.req_we = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus0.req = 4'b0001;
            rst0 = (c == 2);
            g = (c == 1 || c == 4 || c == 5) ? 4'b0001 : 4'b0000;
            exp_q.push_back('{gnt: g, busy: (c != 0 && c != 3)});
            rv_q.push_back('{rv: (c == 1) ? 4'b0000 : g, data: 8'hA5});
            @(negedge clk);
            e = exp_q.pop_front();
            r = rv_q.pop_front();
            n_checks += 4;
            if (bus0.gnt !== e.gnt) $display("FAIL rstmid c%0d gnt got %b exp %b", c, bus0.gnt, e.gnt); else n_pass++;
            if (bus0.busy !== e.busy) $display("FAIL rstmid c%0d busy got %b exp %b", c, bus0.busy, e.busy); else n_pass++;
            if (bus0.rvalid !== r.rv) $display("FAIL rstmid c%0d rvalid got %b exp %b", c, bus0.rvalid, r.rv); else n_pass++;
            if (bus0.mem_en !== (e.gnt != 4'b0000)) $display("FAIL rstmid c%0d mem_en got %b exp %b", c, bus0.mem_en, (e.gnt != 4'b0000)); else n_pass++;
            $display("rstmid c%0d rst=%b gnt=%b rvalid=%b busy=%b", c, rst0, bus0.gnt, bus0.rvalid, bus0.busy);
        end
        rst0 = 1'b0;
    endtask

    task automatic test_burst1();
        cyc_t e;
        rv_t  r;
        logic [3:0] g;
        apply_reset();
        bus1.req_we = 4'b0000;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            bus1.req = 4'b0110;
            if (c % 2 == 0)       g = 4'b0000;
            else if (c % 4 == 1)  g = 4'b0010;
            else                  g = 4'b0100;
            exp_q.push_back('{gnt: g, busy: (c % 2 == 1)});
            rv_q.push_back('{rv: g, data: exp_data((g == 4'b0010) ? 1 : 2)});
            @(negedge clk);
            e = exp_q.pop_front();
            r = rv_q.pop_front();
            n_checks += 3;
            if (bus1.gnt !== e.gnt) $display("FAIL burst1 c%0d gnt got %b exp %b", c, bus1.gnt, e.gnt); else n_pass++;
            if (bus1.busy !== e.busy) $display("FAIL burst1 c%0d busy got %b exp %b", c, bus1.busy, e.busy); else n_pass++;
            if (bus1.rvalid !== r.rv) $display("FAIL burst1 c%0d rvalid got %b exp %b", c, bus1.rvalid, r.rv); else n_pass++;
            if (r.rv != 4'b0000) begin
                n_checks++;
                if (bus1.rdata !== r.data) $display("FAIL burst1 c%0d rdata got %h exp %h", c, bus1.rdata, r.data); else n_pass++;
            end
            $display("burst1 c%0d gnt=%b rvalid=%b", c, bus1.gnt, bus1.rvalid);
        end
    endtask

    initial begin
        bus0.req       = '0;
        bus0.req_we    = '0;
        bus0.req_addr  = {16'h0023, 16'h0022, 16'h0021, 16'h0010};
        bus0.req_wdata = '0;
        bus1.req       = '0;
        bus1.req_we    = '0;
        bus1.req_addr  = {16'h0023, 16'h0022, 16'h0021, 16'h0010};
        bus1.req_wdata = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single_burst();
        test_rotation();
        test_wrap();
        test_write();
        test_reset_mid_read();
        test_burst1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
